vending_machine_change_fsm: RTL
===============================

Name: vending_machine_change_fsm

Overview:
Parametrised successor to the fixed-price nickel/dime vending FSM. It accumulates credit from nickel, dime and quarter inputs against a configurable price, pulses vend when the price is met, then returns change coin by coin over a valid/ready handshake. A cancel input refunds all credit without vending. It sits between the coin-acceptor front end and the dispenser/coin-hopper back end.

Parameters:
PRICE, 8, item price in nickel units (8 = $0.40); legal range 1..MAX_CREDIT
MAX_CREDIT, 31, maximum credit held, in nickel units; must be >= PRICE
CREDIT_W, $clog2(MAX_CREDIT+1), width of the credit counter; derived, not overridden

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
nickel  input  1  one-cycle coin-inserted strobe, 1 unit
dime  input  1  one-cycle coin-inserted strobe, 2 units
quarter  input  1  one-cycle coin-inserted strobe, 5 units
cancel  input  1  refund request strobe
vend  output  1  one-cycle dispense-item pulse
change_valid  output  1  a change coin is offered
change_dime  output  1  coin type of the offered coin: 1 = dime, 0 = nickel; valid when change_valid=1
change_ready  input  1  hopper accepts the offered coin
coin_reject  output  1  one-cycle pulse: the coin strobed in the previous cycle was not credited (hopper returns it)
credit  output  CREDIT_W  current credit in nickel units
busy  output  1  state is not ACCUM

Behaviour:
- Reset (rst_n=0 sampled at posedge): state=ACCUM, credit=0, vend=0, change_valid=0, change_dime=0, coin_reject=0, busy=0. All outputs are registered. Reset mid-dispense abandons the remaining change with no further handshakes.
- Coin legality: exactly one of nickel/dime/quarter high = legal coin. More than one high, any coin while busy=1, or credit+value > MAX_CREDIT rejects the coin: coin_reject=1 next cycle, credit unchanged.
- ACCUM: a legal coin at cycle N sets credit=credit+value at N+1. If the new credit >= PRICE, next state=VEND; otherwise stay in ACCUM.
- VEND: lasts one cycle; vend=1 and busy=1 during it; credit is loaded with credit-PRICE. Next state=CHANGE if the remainder > 0, else ACCUM. Latency from the completing coin strobe to vend=1 is 2 cycles.
- CHANGE and REFUND share a dispense path. change_valid=1 while credit > 0. change_dime=1 if credit >= 2, else 0 (greedy: dimes first). On change_valid & change_ready, credit decrements by 2 (dime) or 1 (nickel) at the next edge. change_valid and change_dime stay stable while change_ready=0. When credit reaches 0, change_valid=0 in the same cycle the register updates, and next state=ACCUM.
- Cancel: acted on only in ACCUM with credit > 0; next state=REFUND; no vend. Cancel with credit=0, or while busy, is ignored.
- Cancel and a legal coin in the same cycle: the coin is credited first. If that meets PRICE, VEND wins and cancel is dropped; otherwise go to REFUND with the coin included.
- Arithmetic is unsigned in CREDIT_W bits. The saturation check uses CREDIT_W+1 bits so it cannot wrap.
- An illegal state encoding recovers to ACCUM with credit=0.

Decomposition:
- Package vending_machine_pkg holds:
  - the fsm_t enum {ACCUM, VEND, CHANGE, REFUND}
  - coin value constants NICKEL_UNITS=1, DIME_UNITS=2, QUARTER_UNITS=5
- One sub-module, vm_change_dispenser: takes the credit value and a start strobe, runs the greedy dime/nickel valid/ready loop, and returns a done strobe. It is shared by CHANGE and REFUND.

Test Plan:
- PRICE=8: dime ×4 on nonconsecutive cycles -> vend=1 exactly once, 2 cycles after the 4th dime; no change_valid; credit returns to 0.
- PRICE=8: quarter, quarter (credit 10) -> vend pulse, then one dime offered (change_dime=1); hold change_ready=0 for 5 cycles -> offer stays stable; ready=1 -> credit=0, busy=0.
- PRICE=8: nickel, dime, cancel (credit 3) -> no vend; dime then nickel offered; credit=0 after the 2nd handshake.
- nickel+dime strobed together -> coin_reject=1 next cycle, credit unchanged. Coin strobed during CHANGE -> coin_reject=1.
- MAX_CREDIT=31, PRICE=31: quarter ×6 -> credit 30. 7th quarter -> coin_reject=1. Nickel -> credit 31 -> vend.
- rst_n=0 asserted mid-CHANGE with 3 units owed -> next cycle change_valid=0, credit=0, state ACCUM. Cancel + nickel completing PRICE in the same cycle -> vend, no refund.

Source files
------------

// File: rtl/vending_machine_pkg.sv
// Shared types and coin constants for the parametrised vending/change FSM.
package vending_machine_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2,
    REFUND = 2'd3
  } fsm_t;

  localparam int unsigned NICKEL_UNITS  = 1;
  localparam int unsigned DIME_UNITS    = 2;
  localparam int unsigned QUARTER_UNITS = 5;
  localparam int unsigned COIN_W        = 3;
  localparam int unsigned TAKE_W        = 2;

  // Value of the strobed coin; only meaningful when exactly one strobe is high.
  function automatic logic [COIN_W-1:0] coin_units(input logic n, input logic d, input logic q);
    logic [COIN_W-1:0] units;
    units = '0;
    if (q)      units = COIN_W'(QUARTER_UNITS);
    else if (d) units = COIN_W'(DIME_UNITS);
    else if (n) units = COIN_W'(NICKEL_UNITS);
    return units;
  endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Greedy dime/nickel change loop over a valid/ready handshake; shared by CHANGE and REFUND.
module vm_change_dispenser
  import vending_machine_pkg::*;
#(
  parameter int unsigned CREDIT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [CREDIT_W-1:0] i_start_credit,
  input  logic                i_active,
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic                i_ready,
  output logic                o_valid,
  output logic                o_dime,
  output logic [TAKE_W-1:0]   o_take_units_c,
  output logic                o_done_c
);

  logic                r_valid;
  logic                r_dime;
  logic                w_fire;
  logic [TAKE_W-1:0]   w_take;
  logic [CREDIT_W-1:0] w_left;

  // Coin handed over this cycle and what is still owed afterwards.
  always_comb begin
    w_fire = r_valid & i_ready;
    w_take = '0;
    if (w_fire) w_take = r_dime ? TAKE_W'(DIME_UNITS) : TAKE_W'(NICKEL_UNITS);
    w_left = i_credit - CREDIT_W'(w_take);
  end

  assign o_take_units_c = w_take;
  assign o_done_c       = w_fire && (w_left == '0);
  assign o_valid        = r_valid;
  assign o_dime         = r_dime;

  // Offer only changes on a load or an accepted coin, so it is stable while ready is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dime  <= 1'b0;
    end else if (i_start) begin
      r_valid <= (i_start_credit != '0);
      r_dime  <= (i_start_credit >= CREDIT_W'(DIME_UNITS));
    end else if (i_active) begin
      if (w_fire) begin
        r_valid <= (w_left != '0);
        r_dime  <= (w_left >= CREDIT_W'(DIME_UNITS));
      end
    end else begin
      r_valid <= 1'b0;
      r_dime  <= 1'b0;
    end
  end

endmodule

// File: rtl/vending_machine_change_fsm.sv
// Credit accumulator with configurable price, one-cycle vend pulse and coin-by-coin change/refund.
module vending_machine_change_fsm
  import vending_machine_pkg::*;
#(
  parameter  int unsigned PRICE      = 8,
  parameter  int unsigned MAX_CREDIT = 31,
  localparam int unsigned CREDIT_W   = $clog2(MAX_CREDIT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                vend,
  output logic                change_valid,
  output logic                change_dime,
  input  logic                change_ready,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  fsm_t                r_state;
  fsm_t                w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [CREDIT_W-1:0] w_credit_coin;
  logic [CREDIT_W-1:0] w_start_credit;
  logic                r_vend;
  logic                r_busy;
  logic                r_coin_reject;
  logic [COIN_W-1:0]   w_coin_units;
  logic [SUM_W-1:0]    w_sum;
  logic                w_coin_any;
  logic                w_one_coin;
  logic                w_committed;
  logic                w_coin_ok;
  logic                w_start;
  logic                w_active;
  logic [TAKE_W-1:0]   w_take_units;
  logic                w_done;

  // Coin legality; a credit already at price is committed to vending, so coins are refused.
  always_comb begin
    w_coin_any    = nickel | dime | quarter;
    w_one_coin    = $onehot({quarter, dime, nickel});
    w_coin_units  = coin_units(nickel, dime, quarter);
    w_sum         = SUM_W'(r_credit) + SUM_W'(w_coin_units);
    w_committed   = (r_state == ACCUM) && (r_credit >= CREDIT_W'(PRICE));
    w_coin_ok     = w_one_coin && (r_state == ACCUM) && !w_committed &&
                    (w_sum <= SUM_W'(MAX_CREDIT));
    w_credit_coin = w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;
    w_active      = (r_state == CHANGE) || (r_state == REFUND);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_start        = 1'b0;
    w_start_credit = '0;
    case (r_state)
      ACCUM: begin
        w_credit_nxt = w_credit_coin;
        if (w_committed) begin
          w_state_nxt = VEND;
        end else if (cancel && (w_credit_coin != '0) && (w_credit_coin < CREDIT_W'(PRICE))) begin
          w_state_nxt    = REFUND;
          w_start        = 1'b1;
          w_start_credit = w_credit_coin;
        end
      end
      VEND: begin
        w_credit_nxt = r_credit - CREDIT_W'(PRICE);
        if (w_credit_nxt != '0) begin
          w_state_nxt    = CHANGE;
          w_start        = 1'b1;
          w_start_credit = w_credit_nxt;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      CHANGE, REFUND: begin
        w_credit_nxt = r_credit - CREDIT_W'(w_take_units);
        if (w_done) w_state_nxt = ACCUM;
      end
      default: begin
        w_state_nxt  = ACCUM;
        w_credit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ACCUM;
      r_credit      <= '0;
      r_vend        <= 1'b0;
      r_busy        <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_vend        <= (w_state_nxt == VEND);
      r_busy        <= (w_state_nxt != ACCUM);
      r_coin_reject <= w_coin_any & ~w_coin_ok;
    end
  end

  vm_change_dispenser #(
    .CREDIT_W(CREDIT_W)
  ) u_dispenser (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (w_start),
    .i_start_credit (w_start_credit),
    .i_active       (w_active),
    .i_credit       (r_credit),
    .i_ready        (change_ready),
    .o_valid        (change_valid),
    .o_dime         (change_dime),
    .o_take_units_c (w_take_units),
    .o_done_c       (w_done)
  );

  assign vend        = r_vend;
  assign busy        = r_busy;
  assign coin_reject = r_coin_reject;
  assign credit      = r_credit;

endmodule
